monster_formation: RTL and testbench
====================================

MONSTER_FORMATION -- requirements
Module: monster_formation

Interface
REQ-001 Parameter MONSTER_AMOUNT, default 16, number of monster slots N (1..32).
REQ-002 Parameter AMOUNT_WIDTH, default 6, width of count values; SHALL hold N.
REQ-003 Parameters FIRST_STAGE_AMOUNT=8, SECOND_STAGE_AMOUNT=16, BOSS_STAGE_AMOUNT=12, wave size per stage.
REQ-004 Parameters SPAWN_INTERVAL_FRAMES=4, EXPLOSION_FRAMES=10, FIRE_PERIOD_FRAMES=30, all >=1.
REQ-005 Ports (clock and reset first):
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- enable  in  1  frame-tick gate; low freezes all frame counters
- startOfFrame  in  1  one-cycle frame tick
- stage_num  in  3  current stage
- start_wave  in  1  one-cycle wave request
- hit_vector  in  N  per-slot hit, any cycle
- alive  out  N  slot is active and hittable
- exploding  out  N  slot is showing its explosion
- fire_grant  out  N  one-hot, one-cycle shot permission
- monster_died_pulse  out  1  a monster died this cycle
- all_monsters_dead  out  1  wave cleared
- kill_count  out  AMOUNT_WIDTH  kills in current wave
- wave_state  out  2  FSM state encoding

Function
REQ-006 Frame tick = startOfFrame & enable; every frame counter SHALL advance only on a frame tick.
REQ-007 stage_amount: stage 1->FIRST, 2->SECOND, 4->BOSS, else MONSTER_AMOUNT; values above N SHALL clamp to N.
REQ-008 FSM states: IDLE=0, SPAWN=1, ACTIVE=2, CLEARED=3.
REQ-009 IDLE or CLEARED + start_wave: latch stage_amount as wave_amount, clear spawn index, spawn counter and kill_count, go SPAWN next cycle.
REQ-010 start_wave in SPAWN or ACTIVE SHALL be ignored.
REQ-011 SPAWN: spawn counter counts frame ticks 0..SPAWN_INTERVAL_FRAMES-1; on the tick at which it wraps, set alive[spawn index] and increment the index; slot 0 spawns on the SPAWN_INTERVAL_FRAMES-th tick.
REQ-012 SPAWN->ACTIVE in the cycle after spawn index reaches wave_amount; wave_amount=0 goes straight to ACTIVE.
REQ-013 ACTIVE->CLEARED when alive==0 and exploding==0.
REQ-014 hit_vector[i] with alive[i]=1: next cycle alive[i]=0, exploding[i]=1, explosion counter[i]=EXPLOSION_FRAMES, kill_count +1 (saturating).
REQ-015 hit_vector[i] with alive[i]=0 SHALL be ignored; simultaneous hits on several slots SHALL all register in the same cycle.
REQ-016 Explosion counter decrements on each frame tick; exploding[i] clears in the cycle after it reaches 0.
REQ-017 monster_died_pulse SHALL be high for exactly one cycle per cycle in which at least one alive bit falls, coincident with that fall.
REQ-018 all_monsters_dead SHALL be 1 exactly while in CLEARED.
REQ-019 Hits SHALL register regardless of enable or FSM state.

Reset
REQ-020 resetN low, any cycle: state IDLE, alive=0, exploding=0, all counters=0, fire pointer=N-1, every output 0; a wave in progress SHALL be abandoned.

Configuration
REQ-021 Macro MONSTER_FIRE_ARB_EN defined: in ACTIVE, a fire counter counts frame ticks 0..FIRE_PERIOD_FRAMES-1; on wrap, fire_grant pulses one cycle for the first alive slot after the pointer (round robin, wrap N-1->0), and the pointer moves to that slot.
REQ-022 On wrap with no alive slot, no grant; pointer SHALL be unchanged.
REQ-023 Macro undefined: fire_grant tied to 0, no fire counter or pointer logic.

Verification
REQ-024 Reset, stage_num=1, start_wave, 40 frame ticks -> alive=0x00FF after tick 32, wave_state=2 on the following cycle.
REQ-025 ACTIVE, hit_vector=0x0005 for one cycle -> alive bits 0 and 2 clear, monster_died_pulse one cycle, kill_count=2, exploding clears on the 11th frame tick.
REQ-026 Hit all 8 alive slots, 11 ticks -> wave_state=3, all_monsters_dead=1; start_wave -> SPAWN, kill_count=0.
REQ-027 MONSTER_FIRE_ARB_EN, alive=0x0012 -> grants to slots 1, 4, 1 on consecutive 30-tick wraps.
REQ-028 enable=0 for 20 startOfFrame pulses mid-SPAWN -> alive unchanged; hit on alive slot still clears it.
REQ-029 resetN asserted mid-SPAWN -> all outputs 0 asynchronously, wave_state=0.

Source files
------------

// File: rtl/monster_formation.sv
// Wave controller for a row of monster slots: staged spawning, hit handling, explosion timing
// and the IDLE/SPAWN/ACTIVE/CLEARED wave FSM. Define MONSTER_FIRE_ARB_EN for round-robin fire grants.
module monster_formation #(
    parameter int MONSTER_AMOUNT        = 16,
    parameter int AMOUNT_WIDTH          = 6,
    parameter int FIRST_STAGE_AMOUNT    = 8,
    parameter int SECOND_STAGE_AMOUNT   = 16,
    parameter int BOSS_STAGE_AMOUNT     = 12,
    parameter int SPAWN_INTERVAL_FRAMES = 4,
    parameter int EXPLOSION_FRAMES      = 10,
    parameter int FIRE_PERIOD_FRAMES    = 30
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      enable,
    input  logic                      startOfFrame,
    input  logic [2:0]                stage_num,
    input  logic                      start_wave,
    input  logic [MONSTER_AMOUNT-1:0] hit_vector,
    output logic [MONSTER_AMOUNT-1:0] alive,
    output logic [MONSTER_AMOUNT-1:0] exploding,
    output logic [MONSTER_AMOUNT-1:0] fire_grant,
    output logic                      monster_died_pulse,
    output logic                      all_monsters_dead,
    output logic [AMOUNT_WIDTH-1:0]   kill_count,
    output logic [1:0]                wave_state
);

    generate
        if (MONSTER_AMOUNT < 1 || MONSTER_AMOUNT > 32) begin : g_bad_amount
            $error("MONSTER_AMOUNT must be in 1..32");
        end
        if ((1 << AMOUNT_WIDTH) <= MONSTER_AMOUNT) begin : g_bad_width
            $error("AMOUNT_WIDTH too narrow to hold MONSTER_AMOUNT");
        end
        if (SPAWN_INTERVAL_FRAMES < 1 || EXPLOSION_FRAMES < 1 || FIRE_PERIOD_FRAMES < 1) begin : g_bad_frames
            $error("frame periods must be at least 1");
        end
    endgenerate

    localparam int N        = MONSTER_AMOUNT;
    localparam int SPAWN_W  = (SPAWN_INTERVAL_FRAMES > 1) ? $clog2(SPAWN_INTERVAL_FRAMES) : 1;
    localparam int EXP_W    = $clog2(EXPLOSION_FRAMES + 1);
    localparam int FIRST_C  = (FIRST_STAGE_AMOUNT  > N) ? N : FIRST_STAGE_AMOUNT;
    localparam int SECOND_C = (SECOND_STAGE_AMOUNT > N) ? N : SECOND_STAGE_AMOUNT;
    localparam int BOSS_C   = (BOSS_STAGE_AMOUNT   > N) ? N : BOSS_STAGE_AMOUNT;

    localparam logic [SPAWN_W-1:0]      SPAWN_LAST = SPAWN_W'(SPAWN_INTERVAL_FRAMES - 1);
    localparam logic [EXP_W-1:0]        EXP_LOAD   = EXP_W'(EXPLOSION_FRAMES);
    localparam logic [AMOUNT_WIDTH-1:0] KILL_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPAWN   = 2'd1,
        ACTIVE  = 2'd2,
        CLEARED = 2'd3
    } wave_state_t;

    wave_state_t             state, next_state;
    logic                    frame_tick, start_accept, spawn_wrap, spawn_fire;
    logic [AMOUNT_WIDTH-1:0] stage_amount, wave_amount, spawn_idx, hit_count;
    logic [AMOUNT_WIDTH:0]   kill_sum;
    logic [SPAWN_W-1:0]      spawn_cnt;
    logic [N-1:0]            new_hits, spawn_mask;
    logic [EXP_W-1:0]        exp_cnt [N];

    assign frame_tick   = startOfFrame & enable;
    assign new_hits     = hit_vector & alive;
    assign start_accept = start_wave && (state == IDLE || state == CLEARED);
    assign spawn_wrap   = frame_tick && (spawn_cnt == SPAWN_LAST);
    assign spawn_fire   = (state == SPAWN) && spawn_wrap && (spawn_idx < wave_amount);
    assign kill_sum     = {1'b0, kill_count} + {1'b0, hit_count};

    always_comb begin
        stage_amount = AMOUNT_WIDTH'(N);
        case (stage_num)
            3'd1:    stage_amount = AMOUNT_WIDTH'(FIRST_C);
            3'd2:    stage_amount = AMOUNT_WIDTH'(SECOND_C);
            3'd4:    stage_amount = AMOUNT_WIDTH'(BOSS_C);
            default: ;
        endcase
    end

    always_comb begin
        hit_count  = '0;
        spawn_mask = '0;
        for (int i = 0; i < N; i++) begin
            hit_count     = hit_count + AMOUNT_WIDTH'(new_hits[i]);
            spawn_mask[i] = (AMOUNT_WIDTH'(i) == spawn_idx);
        end
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_accept) next_state = SPAWN;
            SPAWN:   if (spawn_idx == wave_amount) next_state = ACTIVE;
            ACTIVE:  if (alive == '0 && exploding == '0) next_state = CLEARED;
            CLEARED: if (start_accept) next_state = SPAWN;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wave_amount <= '0;
            spawn_idx   <= '0;
            spawn_cnt   <= '0;
        end else if (start_accept) begin
            wave_amount <= stage_amount;
            spawn_idx   <= '0;
            spawn_cnt   <= '0;
        end else if (state == SPAWN && frame_tick) begin
            spawn_cnt <= spawn_wrap ? '0 : spawn_cnt + SPAWN_W'(1);
            if (spawn_fire) begin
                spawn_idx <= spawn_idx + AMOUNT_WIDTH'(1);
            end
        end
    end

    // A hit wins over any explosion already running on the slot; the slot cannot be alive then anyway.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            alive     <= '0;
            exploding <= '0;
            // NOTE: the counter array is reset element by element; an array is only cleared if each entry is assigned.
            for (int i = 0; i < N; i++) begin
                exp_cnt[i] <= '0;
            end
        end else begin
            alive <= (alive & ~new_hits) | (spawn_fire ? spawn_mask : '0);
            for (int i = 0; i < N; i++) begin
                if (new_hits[i]) begin
                    exploding[i] <= 1'b1;
                    exp_cnt[i]   <= EXP_LOAD;
                end else if (exploding[i]) begin
                    if (exp_cnt[i] == '0) begin
                        exploding[i] <= 1'b0;
                    end else if (frame_tick) begin
                        exp_cnt[i] <= exp_cnt[i] - EXP_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            kill_count         <= '0;
            monster_died_pulse <= 1'b0;
        end else begin
            monster_died_pulse <= |new_hits;
            if (start_accept) begin
                kill_count <= '0;
            end else if (kill_sum[AMOUNT_WIDTH]) begin
                kill_count <= KILL_MAX;
            end else begin
                kill_count <= kill_sum[AMOUNT_WIDTH-1:0];
            end
        end
    end

    assign wave_state        = state;
    assign all_monsters_dead = (state == CLEARED);

`ifdef MONSTER_FIRE_ARB_EN
    localparam int FIRE_W = (FIRE_PERIOD_FRAMES > 1) ? $clog2(FIRE_PERIOD_FRAMES) : 1;
    localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(FIRE_PERIOD_FRAMES - 1);
    localparam logic [PTR_W-1:0]  PTR_INIT  = PTR_W'(N - 1);

    logic [FIRE_W-1:0] fire_cnt;
    logic [PTR_W-1:0]  fire_ptr, rr_sel, rr_hi, rr_lo;
    logic              rr_hi_found, rr_lo_found, fire_wrap;
    logic [N-1:0]      rr_onehot;

    // Lowest alive slot above the pointer, otherwise wrap to the lowest alive slot overall.
    always_comb begin
        rr_hi       = '0;
        rr_lo       = '0;
        rr_hi_found = 1'b0;
        rr_lo_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (alive[i]) begin
                rr_lo       = PTR_W'(i);
                rr_lo_found = 1'b1;
                if (PTR_W'(i) > fire_ptr) begin
                    rr_hi       = PTR_W'(i);
                    rr_hi_found = 1'b1;
                end
            end
        end
        rr_sel    = rr_hi_found ? rr_hi : rr_lo;
        rr_onehot = '0;
        for (int i = 0; i < N; i++) begin
            rr_onehot[i] = (PTR_W'(i) == rr_sel);
        end
    end

    assign fire_wrap = frame_tick && (fire_cnt == FIRE_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_cnt   <= '0;
            fire_ptr   <= PTR_INIT;
            fire_grant <= '0;
        end else begin
            fire_grant <= '0;
            if (state != ACTIVE) begin
                fire_cnt <= '0;
            end else if (frame_tick) begin
                if (fire_wrap) begin
                    fire_cnt <= '0;
                    if (rr_lo_found) begin
                        fire_grant <= rr_onehot;
                        fire_ptr   <= rr_sel;
                    end
                end else begin
                    fire_cnt <= fire_cnt + FIRE_W'(1);
                end
            end
        end
    end
`else
    assign fire_grant = '0;
`endif

endmodule

// File: tb/tb_monster_formation.sv
// Directed scoreboard bench for monster_formation: spawn timing, hits, explosions, wave FSM,
// enable gating, asynchronous reset and (with MONSTER_FIRE_ARB_EN) round-robin fire grants.
module tb_monster_formation;

    localparam int N  = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          resetN;
    logic          enable;
    logic          startOfFrame;
    logic [2:0]    stage_num;
    logic          start_wave;
    logic [N-1:0]  hit_vector;
    logic [N-1:0]  alive;
    logic [N-1:0]  exploding;
    logic [N-1:0]  fire_grant;
    logic          monster_died_pulse;
    logic          all_monsters_dead;
    logic [AW-1:0] kill_count;
    logic [1:0]    wave_state;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t         sb_q [$];
    logic [N-1:0] grant_q [$];
    logic [N-1:0] exp_grant;
    int           compared   = 0;
    int           mismatched = 0;

    monster_formation dut (
        .clk               (clk),
        .resetN            (resetN),
        .enable            (enable),
        .startOfFrame      (startOfFrame),
        .stage_num         (stage_num),
        .start_wave        (start_wave),
        .hit_vector        (hit_vector),
        .alive             (alive),
        .exploding         (exploding),
        .fire_grant        (fire_grant),
        .monster_died_pulse(monster_died_pulse),
        .all_monsters_dead (all_monsters_dead),
        .kill_count        (kill_count),
        .wave_state        (wave_state)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] observed);
        exp_t e;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_underflow: observed %0h expected <none>", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value) else begin
                mismatched++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic check_all_zero(input string prefix);
        expect_val({prefix, "_alive"}, 0);
        expect_val({prefix, "_exploding"}, 0);
        expect_val({prefix, "_wave_state"}, 0);
        expect_val({prefix, "_kill_count"}, 0);
        expect_val({prefix, "_all_dead"}, 0);
        expect_val({prefix, "_died_pulse"}, 0);
        expect_val({prefix, "_fire_grant"}, 0);
        observe(32'(alive));
        observe(32'(exploding));
        observe(32'(wave_state));
        observe(32'(kill_count));
        observe(32'(all_monsters_dead));
        observe(32'(monster_died_pulse));
        observe(32'(fire_grant));
    endtask

    // Called at a falling edge; returns at the falling edge after the ticked rising edge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            @(negedge clk);
            startOfFrame = 1'b0;
        end
    endtask

    task automatic hit(input logic [N-1:0] v);
        hit_vector = v;
        @(negedge clk);
        hit_vector = '0;
    endtask

    task automatic pulse_start();
        start_wave = 1'b1;
        @(negedge clk);
        start_wave = 1'b0;
    endtask

    // Every non-zero grant must match the next expected grant.
    always @(negedge clk) begin
        if (resetN === 1'b1 && fire_grant !== '0) begin
            compared++;
            if (grant_q.size() == 0) begin
                mismatched++;
                $error("FAIL fire_grant_unexpected: observed %0h expected none", fire_grant);
            end else begin
                exp_grant = grant_q.pop_front();
                assert (fire_grant === exp_grant) else begin
                    mismatched++;
                    $error("FAIL fire_grant: observed %0h expected %0h", fire_grant, exp_grant);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN       = 1'b0;
        enable       = 1'b1;
        startOfFrame = 1'b0;
        stage_num    = 3'd0;
        start_wave   = 1'b0;
        hit_vector   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");

        resetN = 1'b1;
        @(negedge clk);

        // Wave 1, stage 1: eight slots, one every four ticks.
        stage_num = 3'd1;
        expect_val("w1_state_spawn", 1);
        pulse_start();
        observe(32'(wave_state));
        ticks(3);
        expect_val("w1_alive_tick3", 0);
        observe(32'(alive));
        ticks(1);
        expect_val("w1_alive_tick4", 32'h0001);
        observe(32'(alive));
        ticks(24);
        expect_val("w1_alive_tick28", 32'h007F);
        observe(32'(alive));
        ticks(4);
        expect_val("w1_alive_tick32", 32'h00FF);
        observe(32'(alive));
        @(negedge clk);
        expect_val("w1_state_active", 2);
        observe(32'(wave_state));
        ticks(8);
        expect_val("w1_alive_tick40", 32'h00FF);
        expect_val("w1_state_tick40", 2);
        observe(32'(alive));
        observe(32'(wave_state));

        // Double hit plus a hit on a dead slot.
        expect_val("hit5_alive", 32'h00FA);
        expect_val("hit5_died_pulse", 1);
        expect_val("hit5_kill", 2);
        expect_val("hit5_exploding", 32'h0005);
        hit(16'h0205);
        observe(32'(alive));
        observe(32'(monster_died_pulse));
        observe(32'(kill_count));
        observe(32'(exploding));
        @(negedge clk);
        expect_val("hit5_pulse_drop", 0);
        observe(32'(monster_died_pulse));
        ticks(10);
        expect_val("expl_tick10", 32'h0005);
        observe(32'(exploding));
        ticks(1);
        expect_val("expl_tick11", 0);
        observe(32'(exploding));

        // Clear the rest of the wave.
        expect_val("clear_alive", 0);
        expect_val("clear_kill", 8);
        expect_val("clear_exploding", 32'h00FA);
        hit(16'h00FF);
        observe(32'(alive));
        observe(32'(kill_count));
        observe(32'(exploding));
        ticks(10);
        expect_val("clear_state_tick10", 2);
        observe(32'(wave_state));
        ticks(1);
        repeat (2) @(negedge clk);
        expect_val("cleared_state", 3);
        expect_val("cleared_all_dead", 1);
        expect_val("cleared_exploding", 0);
        observe(32'(wave_state));
        observe(32'(all_monsters_dead));
        observe(32'(exploding));

        // Wave 2, stage 2, with enable gating and an ignored restart.
        stage_num = 3'd2;
        expect_val("w2_state_spawn", 1);
        expect_val("w2_kill_zero", 0);
        expect_val("w2_all_dead", 0);
        pulse_start();
        observe(32'(wave_state));
        observe(32'(kill_count));
        observe(32'(all_monsters_dead));
        ticks(12);
        expect_val("w2_alive_tick12", 32'h0007);
        observe(32'(alive));
        enable = 1'b0;
        ticks(20);
        expect_val("gated_alive", 32'h0007);
        expect_val("gated_state", 1);
        observe(32'(alive));
        observe(32'(wave_state));
        expect_val("gated_hit_alive", 32'h0005);
        expect_val("gated_hit_pulse", 1);
        expect_val("gated_hit_kill", 1);
        expect_val("gated_hit_exploding", 32'h0002);
        hit(16'h0002);
        observe(32'(alive));
        observe(32'(monster_died_pulse));
        observe(32'(kill_count));
        observe(32'(exploding));
        stage_num = 3'd4;
        expect_val("restart_ignored_state", 1);
        expect_val("restart_ignored_kill", 1);
        pulse_start();
        observe(32'(wave_state));
        observe(32'(kill_count));
        enable = 1'b1;
        ticks(4);
        expect_val("w2_alive_resume", 32'h000D);
        observe(32'(alive));

        // Asynchronous reset between clock edges, mid-spawn.
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        // Boss wave (12 slots), then leave slots 1 and 4 alive for fire arbitration.
        stage_num = 3'd4;
        expect_val("boss_state_spawn", 1);
        pulse_start();
        observe(32'(wave_state));
        ticks(48);
        expect_val("boss_alive", 32'h0FFF);
        observe(32'(alive));
        @(negedge clk);
        expect_val("boss_state_active", 2);
        observe(32'(wave_state));
`ifdef MONSTER_FIRE_ARB_EN
        grant_q.push_back(16'h0002);
        grant_q.push_back(16'h0010);
        grant_q.push_back(16'h0002);
`endif
        expect_val("boss_hit_alive", 32'h0012);
        expect_val("boss_hit_kill", 10);
        hit(16'h0FED);
        observe(32'(alive));
        observe(32'(kill_count));
        ticks(90);
        @(negedge clk);
        expect_val("grants_outstanding", 0);
        observe(32'(grant_q.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
